bin2bcd_seq: RTL and testbench

Iterative, parametrised binary-to-BCD converter (shift-and-add-3, "double dabble") with valid/ready handshakes on both sides. It is the area-lean successor of the single-cycle flash converter. It trades latency (C_BIN_W/C_STEP cycles) for a datapath of only C_STEP×C_DIG digit correctors, and adds backpressure, overflow detection and optional signed input. It sits between a binary counter/measurement source and a 7-segment or ASCII formatter.

---
 rtl/bin2bcd_seq.sv | 205 ++++++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq -- iterative binary-to-BCD converter (shift-and-add-3).
//
// Converts a C_BIN_W-bit binary operand into C_DIG packed BCD digits,
// consuming C_STEP operand bits per enabled clock. A conversion takes
// C_BIN_W/C_STEP enabled cycles in SHIFT, bracketed by one IDLE accept
// cycle and one DONE handshake cycle.
//
// Parameters:
//   C_BIN_W  binary operand width, 4..64
//   C_DIG    number of BCD digits produced, 1..20
//   C_STEP   bits consumed per cycle, 1/2/4/8, must divide C_BIN_W
//
// Ports:
//   CK_i     clock, rising edge
//   RST_i    synchronous active-high reset, wins over EN_CK_i
//   EN_CK_i  clock enable; low freezes every register
//   DAT_i    binary operand, sampled on accept
//   VLD_i    operand valid
//   RDY_o    converter idle and able to accept
//   QQ_o     BCD result, digit k at [4k+3:4k]
//   SIGN_o   result sign (1 = negative), 0 in the unsigned build
//   OVF_o    result did not fit in C_DIG digits (QQ_o = value mod 10^C_DIG)
//   QV_o     result valid
//   QRDY_i   downstream ready
//
// Build option:
//   BIN2BCD_SEQ_SIGN_EN  when defined, DAT_i is two's complement; the
//                        magnitude is converted and the sign reported on
//                        SIGN_o. When undefined DAT_i is unsigned and no
//                        negation logic exists. Latency is the same.
// ---------------------------------------------------------------------------

// One digit corrector: a digit of 5 or more gets +3 so the following
// left shift carries correctly into the next decade.
module bin2bcd_seq_dig (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin2bcd_seq #(
    parameter int C_BIN_W = 32,
    parameter int C_DIG   = 10,
    parameter int C_STEP  = 1
) (
    input  logic                 CK_i,
    input  logic                 RST_i,
    input  logic                 EN_CK_i,
    input  logic [C_BIN_W-1:0]   DAT_i,
    input  logic                 VLD_i,
    output logic                 RDY_o,
    output logic [4*C_DIG-1:0]   QQ_o,
    output logic                 SIGN_o,
    output logic                 OVF_o,
    output logic                 QV_o,
    input  logic                 QRDY_i
);

    localparam int BCD_W = 4 * C_DIG;
    localparam int NSTEP = C_BIN_W / C_STEP;
    localparam int CNT_W = $clog2(NSTEP + 1);

    // Reject illegal parameter sets at elaboration.
    if (C_BIN_W < 4 || C_BIN_W > 64 || C_DIG < 1 || C_DIG > 20 ||
        !(C_STEP == 1 || C_STEP == 2 || C_STEP == 4 || C_STEP == 8) ||
        (C_BIN_W % C_STEP) != 0) begin : g_bad_cfg
        $error("bin2bcd_seq: illegal parameters C_BIN_W=%0d C_DIG=%0d C_STEP=%0d",
               C_BIN_W, C_DIG, C_STEP);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [C_BIN_W-1:0]   sr;        // remaining operand bits, MSB next
    logic [BCD_W-1:0]     bcd;       // BCD accumulator
    logic                 ovf_acc;   // sticky: a 1 left the top digit
    logic [CNT_W-1:0]     cnt;       // SHIFT cycles still to run
    logic [C_BIN_W-1:0]   mag;       // magnitude loaded on accept
    logic                 accept;
    logic                 last;

    // IDLE implies RDY_o, so the accept term needs only the state.
    assign accept = (state == IDLE) && VLD_i;
    assign last   = (state == SHIFT) && (cnt == CNT_W'(1));

    // -----------------------------------------------------------------------
    // Datapath: C_STEP chained correct-then-shift iterations.
    // Stage 0 is the registered state; stage C_STEP is the next state.
    // -----------------------------------------------------------------------
    logic [BCD_W-1:0]   bcd_s [C_STEP+1];
    logic [C_BIN_W-1:0] bin_s [C_STEP+1];
    logic               ovf_s [C_STEP+1];
    logic [BCD_W-1:0]   adj_s [C_STEP];

    assign bcd_s[0] = bcd;
    assign bin_s[0] = sr;
    assign ovf_s[0] = ovf_acc;

    for (genvar s = 0; s < C_STEP; s++) begin : g_stage
        for (genvar d = 0; d < C_DIG; d++) begin : g_dig
            bin2bcd_seq_dig u_dig (
                .din  (bcd_s[s][4*d +: 4]),
                .dout (adj_s[s][4*d +: 4])
            );
        end
        // {BCD, bin} shifts left by one; the operand MSB enters digit 0.
        assign bcd_s[s+1] = {adj_s[s][BCD_W-2:0], bin_s[s][C_BIN_W-1]};
        assign bin_s[s+1] = {bin_s[s][C_BIN_W-2:0], 1'b0};
        // The corrected top bit is the decimal carry out of the last digit;
        // dropping it leaves exactly value mod 10^C_DIG in the accumulator.
        assign ovf_s[s+1] = ovf_s[s] | adj_s[s][BCD_W-1];
    end

    // -----------------------------------------------------------------------
    // Operand magnitude and sign
    // -----------------------------------------------------------------------
`ifdef BIN2BCD_SEQ_SIGN_EN
    logic sign_acc;   // sign of the conversion in flight
    logic sign_q;     // sign of the last delivered result

    // Negating the most negative value wraps to itself, which read as
    // unsigned is the correct magnitude 2^(C_BIN_W-1).
    assign mag = DAT_i[C_BIN_W-1] ? -DAT_i : DAT_i;

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            sign_acc <= 1'b0;
            sign_q   <= 1'b0;
        end else if (EN_CK_i) begin
            if (accept)
                sign_acc <= DAT_i[C_BIN_W-1] & (|mag);
            if (last)
                sign_q <= sign_acc;
        end
    end

    assign SIGN_o = sign_q;
`else
    assign mag    = DAT_i;
    assign SIGN_o = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            state   <= IDLE;
            sr      <= '0;
            bcd     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            QQ_o    <= '0;
            OVF_o   <= 1'b0;
            QV_o    <= 1'b0;
            RDY_o   <= 1'b1;
        end else if (EN_CK_i) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr      <= mag;
                        bcd     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(NSTEP);
                        RDY_o   <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr      <= bin_s[C_STEP];
                    bcd     <= bcd_s[C_STEP];
                    ovf_acc <= ovf_s[C_STEP];
                    cnt     <= cnt - CNT_W'(1);
                    // Result is taken straight from the last stage so QV_o
                    // rises on the same edge as the final iteration.
                    if (last) begin
                        QQ_o  <= bcd_s[C_STEP];
                        OVF_o <= ovf_s[C_STEP];
                        QV_o  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (QRDY_i) begin
                        QV_o  <= 1'b0;
                        RDY_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    QV_o  <= 1'b0;
                    RDY_o <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq -- self-checking bench for bin2bcd_seq.
//
// u0: default build (32 bit, 10 digits, 1 bit/cycle) for directed cases.
// u1: 16 bit, 4 digits, 4 bits/cycle for overflow cases and a long random
//     run with random clock-enable and downstream-ready gaps.
// Expected results come from an arithmetic divide-by-ten model and travel
// through one scoreboard queue per instance.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [79:0] qq;
        logic        ovf;
        logic        sign;
    } entry_t;

    localparam int NOPS   = 2000;
    localparam int NSTEP1 = 4;

    logic        clk;
    logic        rst;

    logic        en0, vld0, rdy0, sign0, ovf0, qv0, qrdy0;
    logic [31:0] dat0;
    logic [39:0] qq0;

    logic        en1, vld1, rdy1, sign1, ovf1, qv1, qrdy1;
    logic [15:0] dat1;
    logic [15:0] qq1;

    int checks = 0;
    int errors = 0;

    entry_t q0[$];
    entry_t q1[$];

    bin2bcd_seq #(.C_BIN_W(32), .C_DIG(10), .C_STEP(1)) u0 (
        .CK_i(clk), .RST_i(rst), .EN_CK_i(en0), .DAT_i(dat0), .VLD_i(vld0),
        .RDY_o(rdy0), .QQ_o(qq0), .SIGN_o(sign0), .OVF_o(ovf0), .QV_o(qv0),
        .QRDY_i(qrdy0)
    );

    bin2bcd_seq #(.C_BIN_W(16), .C_DIG(4), .C_STEP(4)) u1 (
        .CK_i(clk), .RST_i(rst), .EN_CK_i(en1), .DAT_i(dat1), .VLD_i(vld1),
        .RDY_o(rdy1), .QQ_o(qq1), .SIGN_o(sign1), .OVF_o(ovf1), .QV_o(qv1),
        .QRDY_i(qrdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_nonempty(input string tag, input int size);
        checks++;
        assert (size != 0) else begin
            errors++;
            $error("FAIL %s: got result with empty scoreboard (size %0d) expected size > 0", tag, size);
        end
    endtask

    // Reference: width-w operand, dig digits, value mod 10^dig plus overflow.
    function automatic entry_t model(input logic [63:0] v, input int w, input int dig);
        logic [63:0] mask;
        logic [63:0] mag;
        entry_t      e;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        mag  = v & mask;
        e    = '0;
`ifdef BIN2BCD_SEQ_SIGN_EN
        if (mag[w-1]) begin
            e.sign = 1'b1;
            mag    = ((~mag) + 64'd1) & mask;
        end
`endif
        for (int k = 0; k < 20; k++) begin
            if (k < dig) begin
                e.qq[4*k +: 4] = 4'(mag % 64'd10);
                mag = mag / 64'd10;
            end
        end
        e.ovf = (mag != 64'd0);
        return e;
    endfunction

    // Waits for u0's result (entered just after the accept edge), with an
    // optional run of disabled cycles at the start of SHIFT.
    task automatic u0_wait_result(input int exp_lat, input int stall);
        int     lat;
        entry_t e;
        lat = 0;
        en0 = (stall == 0);
        while (!qv0 && lat < 200) begin
            @(negedge clk);
            lat++;
            en0 = (lat >= stall);
        end
        en0 = 1'b1;
        chk("u0_latency", lat, exp_lat);
        if (qv0) begin
            chk_nonempty("u0_scoreboard", q0.size());
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("u0_qq",   qq0,   e.qq);
                chk("u0_ovf",  ovf0,  e.ovf);
                chk("u0_sign", sign0, e.sign);
                chk("u0_rdy_in_done", rdy0, 1'b0);
            end
        end
        if (qrdy0) begin
            @(negedge clk);
            chk("u0_qv_one_cycle", qv0, 1'b0);
            chk("u0_rdy_after_done", rdy0, 1'b1);
        end
    endtask

    task automatic u0_conv(input logic [31:0] v, input int stall);
        @(negedge clk);
        chk("u0_rdy_idle", rdy0, 1'b1);
        vld0 = 1'b1;
        dat0 = v;
        q0.push_back(model({32'd0, v}, 32, 10));
        @(negedge clk);
        vld0 = 1'b0;
        u0_wait_result(32 + stall, stall);
    endtask

    function automatic logic [15:0] next_op(input int i);
        case (i)
            0:       return 16'd12345;
            1:       return 16'd9999;
            2:       return 16'd0;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        entry_t e;
        int     idx, popped, cyc, lat1;
        bit     inflight, prev_en, acc_flag;

        rst = 1'b1;
        en0 = 1'b1; vld0 = 1'b0; dat0 = '0; qrdy0 = 1'b1;
        en1 = 1'b1; vld1 = 1'b0; dat1 = '0; qrdy1 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rdy0",  rdy0,  1'b1);
        chk("rst_qv0",   qv0,   1'b0);
        chk("rst_qq0",   qq0,   40'd0);
        chk("rst_ovf0",  ovf0,  1'b0);
        chk("rst_sign0", sign0, 1'b0);
        chk("rst_rdy1",  rdy1,  1'b1);
        chk("rst_qv1",   qv1,   1'b0);
        rst = 1'b0;

        // All ones, exact 32-cycle latency, one-cycle QV
        u0_conv(32'hFFFF_FFFF, 0);
`ifndef BIN2BCD_SEQ_SIGN_EN
        chk("u0_allones_held", qq0, 40'h42_9496_7295);
`endif
        u0_conv(32'd0, 0);
        chk("u0_zero_ovf", ovf0, 1'b0);

        // Stall 5 disabled cycles inside SHIFT
        u0_conv(32'd1234567890, 5);

        // Downstream holds off 20 cycles; a new VLD must wait
        qrdy0 = 1'b0;
        @(negedge clk);
        vld0 = 1'b1;
        dat0 = 32'd123456789;
        q0.push_back(model(64'd123456789, 32, 10));
        @(negedge clk);
        vld0 = 1'b1;
        dat0 = 32'd42;
        u0_wait_result(32, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("u0_hold_qv",  qv0,  1'b1);
            chk("u0_hold_rdy", rdy0, 1'b0);
            chk("u0_hold_qq",  qq0,  40'h01_2345_6789);
        end
        qrdy0 = 1'b1;
        @(negedge clk);
        chk("u0_after_hs_rdy", rdy0, 1'b1);
        chk("u0_after_hs_qv",  qv0,  1'b0);
        q0.push_back(model(64'd42, 32, 10));
        @(negedge clk);
        vld0 = 1'b0;
        chk("u0_accepted_rdy", rdy0, 1'b0);
        u0_wait_result(32, 0);

        // Reset in the middle of SHIFT aborts the conversion
        @(negedge clk);
        vld0 = 1'b1;
        dat0 = 32'hDEAD_BEEF;
        @(negedge clk);
        vld0 = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rdy", rdy0, 1'b1);
        chk("abort_qv",  qv0,  1'b0);
        chk("abort_qq",  qq0,  40'd0);
        chk("abort_ovf", ovf0, 1'b0);
        repeat (40) @(negedge clk);
        chk("abort_no_result", qv0, 1'b0);
        u0_conv(32'd7, 0);
        chk("u0_seven_held", qq0, 40'h00_0000_0007);

`ifdef BIN2BCD_SEQ_SIGN_EN
        u0_conv(32'h8000_0000, 0);
        chk("s_minmag_qq",   qq0,   40'h21_4748_3648);
        chk("s_minmag_sign", sign0, 1'b1);
        u0_conv(32'hFFFF_FFFF, 0);
        chk("s_minus1_qq",   qq0,   40'd1);
        chk("s_minus1_sign", sign0, 1'b1);
        u0_conv(32'd0, 0);
        chk("s_zero_sign",   sign0, 1'b0);
`else
        chk("u_sign_tied", sign0, 1'b0);
`endif

        // u1: random traffic with random enable/ready gaps
        idx = 0; popped = 0; cyc = 0; lat1 = 0;
        inflight = 1'b0; prev_en = 1'b1; acc_flag = 1'b0;
        while ((idx < NOPS || q1.size() != 0 || vld1) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (inflight && prev_en) lat1++;
            if (acc_flag) begin
                vld1 = 1'b0;
                acc_flag = 1'b0;
            end
            en1   = ($urandom_range(0, 3) != 0);
            qrdy1 = ($urandom_range(0, 2) != 0);
            if (!vld1 && idx < NOPS && $urandom_range(0, 1) == 1) begin
                vld1 = 1'b1;
                dat1 = next_op(idx);
            end
            if (qv1 && inflight) begin
                chk("u1_latency", lat1, NSTEP1);
                inflight = 1'b0;
            end
            if (qv1 && qrdy1 && en1) begin
                chk_nonempty("u1_scoreboard", q1.size());
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    popped++;
                    chk("u1_qq",   qq1,   e.qq);
                    chk("u1_ovf",  ovf1,  e.ovf);
                    chk("u1_sign", sign1, e.sign);
                end
            end
            if (rdy1 && vld1 && en1) begin
                q1.push_back(model({48'd0, dat1}, 16, 4));
                idx++;
                inflight = 1'b1;
                lat1 = -1;
                acc_flag = 1'b1;
            end
            prev_en = en1;
        end
        en1 = 1'b1;
        qrdy1 = 1'b1;
        chk("u1_all_accepted", idx, NOPS);
        chk("u1_all_delivered", popped, NOPS);
        chk("u1_queue_drained", q1.size(), 0);
        @(negedge clk);
        @(negedge clk);
        chk("u1_idle_end", rdy1, 1'b1);
        chk("u1_no_extra", qv1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
